// File: rtl/data_ram_pkg.sv
// Shared constants and address helpers for the data RAM used by load/store instructions.
package data_ram_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int WORD_LSB       = 2;

  // Callers widen addr to 64 bits, so the same helper serves any ADDR_WIDTH up to 64.
  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
    return (addr >> WORD_LSB) < {32'd0, depth};
  endfunction

endpackage

// File: rtl/data_ram_addr_dec.sv
// Maps a byte address to a word index, plus in-range and misaligned flags.
module data_ram_addr_dec
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  in_range,
  output logic                  misaligned
);

  assign idx        = addr[WORD_LSB +: IDX_W];
  assign in_range   = addr_in_range(64'(addr), DEPTH);
  assign misaligned = |addr[WORD_LSB-1:0];

endmodule

// File: rtl/data_ram_unit.sv
// Word-organised data memory: synchronous write, combinational gated read, async clear.
// Optional registered access-error flag `err` when DATA_RAM_UNIT_ERR_EN is defined.
module data_ram_unit
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  write,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] dataout
`ifdef DATA_RAM_UNIT_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("data_ram_unit: DEPTH must be a power of two and at least 4");
  end
  if (ADDR_WIDTH < WORD_LSB + IDX_W || ADDR_WIDTH > 64) begin : g_bad_aw
    $error("data_ram_unit: ADDR_WIDTH cannot cover DEPTH words or exceeds 64");
  end

  logic [IDX_W-1:0]                 idx;
  logic                             in_range;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

`ifdef DATA_RAM_UNIT_ERR_EN
  logic misaligned;
`else
  logic misaligned_unused;
`endif

  data_ram_addr_dec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_dec (
    .addr       (addr),
    .idx        (idx),
    .in_range   (in_range),
`ifdef DATA_RAM_UNIT_ERR_EN
    .misaligned (misaligned)
`else
    .misaligned (misaligned_unused)
`endif
  );

  // Out-of-range writes are dropped here rather than wrapped onto a low word.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                 mem      <= '0;
    else if (write && in_range) mem[idx] <= datain;
  end

  // No bypass: a same-cycle write is visible only after the edge.
  assign dataout = (read && in_range) ? mem[idx] : '0;

`ifdef DATA_RAM_UNIT_ERR_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) err <= 1'b0;
    else       err <= (read | write) & (~in_range | misaligned);
  end
`endif

endmodule

// File: tb/tb_data_ram_unit.sv
// Scoreboard bench for data_ram_unit: expected read data is queued as stimulus is driven.
module tb_data_ram_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 32;

  logic          Clock  = 1'b0;
  logic          Reset  = 1'b0;
  logic          write  = 1'b0;
  logic          read   = 1'b0;
  logic [AW-1:0] addr   = '0;
  logic [DW-1:0] datain = '0;
  logic [DW-1:0] dataout;
`ifdef DATA_RAM_UNIT_ERR_EN
  logic          err;
`endif

  typedef struct {
    string         name;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 Clock = ~Clock;

  data_ram_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .addr    (addr),
    .datain  (datain),
    .write   (write),
    .read    (read),
    .dataout (dataout)
`ifdef DATA_RAM_UNIT_ERR_EN
    ,
    .err     (err)
`endif
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input string n, input logic [DW-1:0] v);
    sb.push_back('{n, v});
  endtask

  task automatic test_reset();
    exp_t e;
    Reset = 1'b1; read = 1'b1; addr = 32'h04;
    push("reset_hold", 32'h0);
    #1; e = sb.pop_front(); checks++;
    if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
    tick();
    Reset = 1'b0;
    push("after_reset", 32'h0);
    #1; e = sb.pop_front(); checks++;
    if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
  endtask

  task automatic test_write_read();
    exp_t e;
    write = 1'b1; datain = 32'h0000FFFF; addr = 32'h04; read = 1'b1;
    push("pre_edge_old", 32'h0);
    #1; e = sb.pop_front(); checks++;
    if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
    tick();
    write = 1'b0;
    push("wr_rd_0x04", 32'h0000FFFF);
    #1; e = sb.pop_front(); checks++;
    if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
    addr = 32'h08;
    push("rd_0x08_empty", 32'h0);
    #1; e = sb.pop_front(); checks++;
    if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
  endtask

  task automatic test_write_noread();
    exp_t e;
    logic [AW-1:0] a_tab [4] = '{32'h08, 32'h08, 32'h0C, 32'h04};
    logic          r_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    write = 1'b1; read = 1'b0; addr = 32'h08; datain = 32'hFFFF0000;
    tick();
    write = 1'b0;
    push("read_low",     32'h0);
    push("rd_0x08",      32'hFFFF0000);
    push("rd_0x0c",      32'h0);
    push("rd_0x04_kept", 32'h0000FFFF);
    for (int i = 0; i < 4; i++) begin
      addr = a_tab[i]; read = r_tab[i];
      #1; e = sb.pop_front(); checks++;
      if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    read = 1'b1;
    for (int i = 5; i < 8; i++) begin
      addr = AW'(i);
      push($sformatf("misaligned_rd_%0d", i), 32'h0000FFFF);
      #1; e = sb.pop_front(); checks++;
      if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
    end
    addr = 32'h05;
    tick();
`ifdef DATA_RAM_UNIT_ERR_EN
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_misaligned: err=%b expected=1", err); end
`endif
    // misaligned store lands in the containing word (0x08)
    write = 1'b1; addr = 32'h0B; datain = 32'h11112222;
    tick();
    write = 1'b0; addr = 32'h08;
    push("misaligned_wr", 32'h11112222);
    #1; e = sb.pop_front(); checks++;
    if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
    tick();
`ifdef DATA_RAM_UNIT_ERR_EN
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_aligned: err=%b expected=0", err); end
`endif
  endtask

  task automatic test_out_of_range();
    exp_t e;
    logic [AW-1:0] a_tab [3] = '{32'h100, 32'h0, 32'h80000004};
    write = 1'b1; read = 1'b0; addr = 32'h100; datain = 32'hDEADBEEF;
    tick();
`ifdef DATA_RAM_UNIT_ERR_EN
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_oor: err=%b expected=1", err); end
`endif
    write = 1'b1; addr = 32'h80000004; datain = 32'h00000BAD;
    tick();
    write = 1'b0; read = 1'b1;
    push("oor_rd_0x100",  32'h0);
    push("word0_intact",  32'h0);
    push("oor_high_bit",  32'h0);
    for (int i = 0; i < 3; i++) begin
      addr = a_tab[i];
      #1; e = sb.pop_front(); checks++;
      if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
    end
    addr = 32'h04;
    push("no_alias_0x04", 32'h0000FFFF);
    #1; e = sb.pop_front(); checks++;
    if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
  endtask

  task automatic test_boundary();
    exp_t e;
    logic [AW-1:0] a_tab [3] = '{32'hFC, 32'hFF, 32'h100};
    write = 1'b1; addr = 32'hFC; datain = 32'h12345678;
    tick();
    write = 1'b0;
    push("last_word",      32'h12345678);
    push("last_word_misa", 32'h12345678);
    push("just_past_end",  32'h0);
    for (int i = 0; i < 3; i++) begin
      addr = a_tab[i];
      #1; e = sb.pop_front(); checks++;
      if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [DW-1:0] model [16];
    for (int i = 0; i < 16; i++) model[i] = '0;
    read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      write = 1'b1; addr = AW'(32'h40 + i * 4); datain = $urandom;
      push($sformatf("b2b_pre_%0d", i), model[i]);
      #1; e = sb.pop_front(); checks++;
      if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
      model[i] = datain;
      tick();
    end
    write = 1'b0;
    for (int i = 0; i < 16; i++) push($sformatf("b2b_rd_%0d", i), model[i]);
    for (int i = 0; i < 16; i++) begin
      addr = AW'(32'h40 + i * 4);
      #1; e = sb.pop_front(); checks++;
      if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
    end
  endtask

  task automatic test_reset_async();
    exp_t e;
    logic [AW-1:0] a_tab [3] = '{32'h10, 32'h04, 32'hFC};
    time t0;
    read = 1'b1; write = 1'b0; addr = 32'h04;
    push("pre_async_reset", 32'h0000FFFF);
    #1; e = sb.pop_front(); checks++;
    if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
    @(posedge Clock);
    t0 = $time;
    #2 Reset = 1'b1;
    push("async_clear", 32'h0);
    #1; e = sb.pop_front(); checks++;
    if (dataout !== e.exp || ($time - t0) >= 10) begin
      fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp);
    end
    write = 1'b1; addr = 32'h10; datain = 32'h0000AAAA;
    tick();
`ifdef DATA_RAM_UNIT_ERR_EN
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_in_reset: err=%b expected=0", err); end
`endif
    write = 1'b0;
    #1 Reset = 1'b0;
    push("wr_in_reset_dropped", 32'h0);
    push("cleared_0x04",        32'h0);
    push("cleared_0xfc",        32'h0);
    for (int i = 0; i < 3; i++) begin
      addr = a_tab[i];
      #1; e = sb.pop_front(); checks++;
      if (dataout !== e.exp) begin fails++; $display("FAIL %s: dataout=%h expected=%h", e.name, dataout, e.exp); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_write_noread();
    test_misaligned();
    test_out_of_range();
    test_boundary();
    test_back_to_back();
    test_reset_async();
    checks++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
